// File: rtl/ctrl_pkg.sv
// Shared encodings and the ID/EX control bundle for the RV32I control pipe.
package ctrl_pkg;

    // Internal ALUOp code width; the top level zero-extends to its ALUOP_W port.
    localparam int ALU_CODE_W = 5;

    localparam logic [4:0] ALU_NOP    = 5'd0;
    localparam logic [4:0] ALU_LUI    = 5'd1;
    localparam logic [4:0] ALU_AUIPC  = 5'd2;
    localparam logic [4:0] ALU_ADD    = 5'd3;
    localparam logic [4:0] ALU_SUB    = 5'd4;
    localparam logic [4:0] ALU_BNE    = 5'd5;
    localparam logic [4:0] ALU_BLT    = 5'd6;
    localparam logic [4:0] ALU_BGE    = 5'd7;
    localparam logic [4:0] ALU_BLTU   = 5'd8;
    localparam logic [4:0] ALU_BGEU   = 5'd9;
    localparam logic [4:0] ALU_SLT    = 5'd10;
    localparam logic [4:0] ALU_SLTU   = 5'd11;
    localparam logic [4:0] ALU_XOR    = 5'd12;
    localparam logic [4:0] ALU_OR     = 5'd13;
    localparam logic [4:0] ALU_AND    = 5'd14;
    localparam logic [4:0] ALU_SLL    = 5'd15;
    localparam logic [4:0] ALU_SRA    = 5'd16;
    localparam logic [4:0] ALU_SRL    = 5'd17;
    // M-extension codes are ALU_MUL + funct3 (mul..remu = 18..25).
    localparam logic [4:0] ALU_MUL    = 5'd18;

    // EXTOp one-hot, bit order {SHAMT,I,S,B,U,J}.
    localparam logic [5:0] EXT_NONE   = 6'b000000;
    localparam logic [5:0] EXT_SHAMT  = 6'b100000;
    localparam logic [5:0] EXT_I      = 6'b010000;
    localparam logic [5:0] EXT_S      = 6'b001000;
    localparam logic [5:0] EXT_B      = 6'b000100;
    localparam logic [5:0] EXT_U      = 6'b000010;
    localparam logic [5:0] EXT_J      = 6'b000001;

    localparam logic [1:0] WD_ALU     = 2'b00;
    localparam logic [1:0] WD_MEM     = 2'b01;
    localparam logic [1:0] WD_PC      = 2'b10;

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JAL    = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MEXT    = 7'b0000001;

    // Everything the EX stage needs; all-zero is a bubble.
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       alu_src;
        logic [5:0] ext_op;
        logic [4:0] alu_op;
        logic [2:0] npc_op;
        logic [1:0] wd_sel;
        logic [2:0] dm_type;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/rv_decoder.sv
// Purely combinational RV32I (+ optional M) decoder producing the control bundle.
module rv_decoder
    import ctrl_pkg::*;
#(
    parameter int ENABLE_MEXT = 0
) (
    input  logic [31:0]  inst,
    output ctrl_bundle_t ctrl,
    output logic         uses_rs1,
    output logic         uses_rs2,
    output logic         illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_f;
    logic [4:0] rs1_f;
    logic [4:0] rs2_f;

    assign opcode = inst[6:0];
    assign rd_f   = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1_f  = inst[19:15];
    assign rs2_f  = inst[24:20];
    assign funct7 = inst[31:25];

    // Decode by format; unused register fields stay 0, and illegal encodings collapse to a bubble.
    always_comb begin
        ctrl     = CTRL_BUBBLE;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.ext_op    = EXT_U;
                ctrl.alu_op    = (opcode == OPC_LUI) ? ALU_LUI : ALU_AUIPC;
                ctrl.wd_sel    = WD_ALU;
                ctrl.rd        = rd_f;
            end
            OPC_JAL: begin
                ctrl.reg_write = 1'b1;
                ctrl.ext_op    = EXT_J;
                ctrl.alu_op    = ALU_NOP;
                ctrl.npc_op    = NPC_JAL;
                ctrl.wd_sel    = WD_PC;
                ctrl.rd        = rd_f;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.ext_op    = EXT_I;
                    ctrl.alu_op    = ALU_NOP;
                    ctrl.npc_op    = NPC_JALR;
                    ctrl.wd_sel    = WD_PC;
                    ctrl.rd        = rd_f;
                    ctrl.rs1       = rs1_f;
                    uses_rs1       = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_BRANCH: begin
                ctrl.ext_op = EXT_B;
                ctrl.npc_op = NPC_BRANCH;
                ctrl.rs1    = rs1_f;
                ctrl.rs2    = rs2_f;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
                case (funct3)
                    3'b000:  ctrl.alu_op = ALU_SUB;
                    3'b001:  ctrl.alu_op = ALU_BNE;
                    3'b100:  ctrl.alu_op = ALU_BLT;
                    3'b101:  ctrl.alu_op = ALU_BGE;
                    3'b110:  ctrl.alu_op = ALU_BLTU;
                    3'b111:  ctrl.alu_op = ALU_BGEU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                ctrl.reg_write = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.ext_op    = EXT_I;
                ctrl.alu_op    = ALU_ADD;
                ctrl.wd_sel    = WD_MEM;
                ctrl.dm_type   = funct3;
                ctrl.rd        = rd_f;
                ctrl.rs1       = rs1_f;
                uses_rs1       = 1'b1;
                case (funct3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.ext_op    = EXT_S;
                ctrl.alu_op    = ALU_ADD;
                ctrl.dm_type   = funct3;
                ctrl.rs1       = rs1_f;
                ctrl.rs2       = rs2_f;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
                if (funct3 > 3'b010) begin
                    illegal = 1'b1;
                end
            end
            OPC_OPIMM: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.ext_op    = EXT_I;
                ctrl.rd        = rd_f;
                ctrl.rs1       = rs1_f;
                uses_rs1       = 1'b1;
                case (funct3)
                    3'b000: ctrl.alu_op = ALU_ADD;
                    3'b010: ctrl.alu_op = ALU_SLT;
                    3'b011: ctrl.alu_op = ALU_SLTU;
                    3'b100: ctrl.alu_op = ALU_XOR;
                    3'b110: ctrl.alu_op = ALU_OR;
                    3'b111: ctrl.alu_op = ALU_AND;
                    3'b001: begin
                        ctrl.ext_op = EXT_SHAMT;
                        ctrl.alu_op = ALU_SLL;
                        if (funct7 != F7_BASE) illegal = 1'b1;
                    end
                    default: begin
                        ctrl.ext_op = EXT_SHAMT;
                        if (funct7 == F7_BASE)     ctrl.alu_op = ALU_SRL;
                        else if (funct7 == F7_ALT) ctrl.alu_op = ALU_SRA;
                        else                       illegal = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                ctrl.reg_write = 1'b1;
                ctrl.rd        = rd_f;
                ctrl.rs1       = rs1_f;
                ctrl.rs2       = rs2_f;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  ctrl.alu_op = ALU_ADD;
                        3'b001:  ctrl.alu_op = ALU_SLL;
                        3'b010:  ctrl.alu_op = ALU_SLT;
                        3'b011:  ctrl.alu_op = ALU_SLTU;
                        3'b100:  ctrl.alu_op = ALU_XOR;
                        3'b101:  ctrl.alu_op = ALU_SRL;
                        3'b110:  ctrl.alu_op = ALU_OR;
                        default: ctrl.alu_op = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000)      ctrl.alu_op = ALU_SUB;
                    else if (funct3 == 3'b101) ctrl.alu_op = ALU_SRA;
                    else                       illegal = 1'b1;
                end else if (funct7 == F7_MEXT && ENABLE_MEXT != 0) begin
                    ctrl.alu_op = ALU_MUL + {2'b00, funct3};
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            ctrl     = CTRL_BUBBLE;
            uses_rs1 = 1'b0;
            uses_rs2 = 1'b0;
        end else begin
            ctrl.valid = 1'b1;
        end
    end

endmodule

// File: rtl/id_ex_ctrl_pipe.sv
// ID-stage control: decode, load-use hazard detection, flush handling and the ID/EX control register.
module id_ex_ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int ENABLE_MEXT = 0,
    parameter int ALUOP_W     = 5,   // must be >= 5
    parameter int REG_AW      = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [31:0]        id_inst,
    input  logic               flush,
    output logic               stall,
    output logic               ex_valid,
    output logic               ex_RegWrite,
    output logic               ex_MemWrite,
    output logic               ex_MemRead,
    output logic               ex_ALUSrc,
    output logic [5:0]         ex_EXTOp,
    output logic [ALUOP_W-1:0] ex_ALUOp,
    output logic [2:0]         ex_NPCOp,
    output logic [1:0]         ex_WDSel,
    output logic [2:0]         ex_DMType,
    output logic [REG_AW-1:0]  ex_rd,
    output logic [REG_AW-1:0]  ex_rs1,
    output logic [REG_AW-1:0]  ex_rs2,
    output logic               illegal
);

    ctrl_bundle_t dec_ctrl;
    logic         dec_uses_rs1;
    logic         dec_uses_rs2;
    logic         dec_illegal;
    ctrl_bundle_t ex_q;
    ctrl_bundle_t ex_d;
    logic         illegal_q;
    logic         illegal_d;
    logic         hazard;

    rv_decoder #(.ENABLE_MEXT(ENABLE_MEXT)) u_decoder (
        .inst     (id_inst),
        .ctrl     (dec_ctrl),
        .uses_rs1 (dec_uses_rs1),
        .uses_rs2 (dec_uses_rs2),
        .illegal  (dec_illegal)
    );

    // Load-use: the load in EX writes a register the ID instruction reads; x0 never hazards.
    always_comb begin
        hazard = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) &
                 ((dec_uses_rs1 & (dec_ctrl.rs1 == ex_q.rd)) |
                  (dec_uses_rs2 & (dec_ctrl.rs2 == ex_q.rd)));
        stall  = hazard & ~flush;
    end

    // Next ID/EX contents: flush beats stall beats an empty slot; only a real issue can flag illegal.
    always_comb begin
        ex_d      = CTRL_BUBBLE;
        illegal_d = 1'b0;
        if (flush || hazard || !id_valid) begin
            ex_d      = CTRL_BUBBLE;
            illegal_d = 1'b0;
        end else begin
            ex_d      = dec_ctrl;
            illegal_d = dec_illegal;
        end
    end

    // ID/EX control register with synchronous reset to a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q      <= CTRL_BUBBLE;
            illegal_q <= 1'b0;
        end else begin
            ex_q      <= ex_d;
            illegal_q <= illegal_d;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_RegWrite = ex_q.reg_write;
    assign ex_MemWrite = ex_q.mem_write;
    assign ex_MemRead  = ex_q.mem_read;
    assign ex_ALUSrc   = ex_q.alu_src;
    assign ex_EXTOp    = ex_q.ext_op;
    assign ex_ALUOp    = ALUOP_W'(ex_q.alu_op);
    assign ex_NPCOp    = ex_q.npc_op;
    assign ex_WDSel    = ex_q.wd_sel;
    assign ex_DMType   = ex_q.dm_type;
    assign ex_rd       = REG_AW'(ex_q.rd);
    assign ex_rs1      = REG_AW'(ex_q.rs1);
    assign ex_rs2      = REG_AW'(ex_q.rs2);
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Directed bench for id_ex_ctrl_pipe: one instance without and one with the M extension.
module tb_id_ex_ctrl_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_inst;
    logic        flush;

    logic        stall, ex_valid, ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc, illegal;
    logic [5:0]  ex_EXTOp;
    logic [4:0]  ex_ALUOp;
    logic [2:0]  ex_NPCOp;
    logic [1:0]  ex_WDSel;
    logic [2:0]  ex_DMType;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2;

    logic        m_stall, m_ex_valid, m_ex_RegWrite, m_ex_MemWrite, m_ex_MemRead, m_ex_ALUSrc, m_illegal;
    logic [5:0]  m_ex_EXTOp;
    logic [4:0]  m_ex_ALUOp;
    logic [2:0]  m_ex_NPCOp;
    logic [1:0]  m_ex_WDSel;
    logic [2:0]  m_ex_DMType;
    logic [4:0]  m_ex_rd, m_ex_rs1, m_ex_rs2;

    int total = 0;
    int bad   = 0;

    id_ex_ctrl_pipe #(.ENABLE_MEXT(0), .ALUOP_W(5), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .flush(flush),
        .stall(stall), .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite),
        .ex_MemRead(ex_MemRead), .ex_ALUSrc(ex_ALUSrc), .ex_EXTOp(ex_EXTOp), .ex_ALUOp(ex_ALUOp),
        .ex_NPCOp(ex_NPCOp), .ex_WDSel(ex_WDSel), .ex_DMType(ex_DMType), .ex_rd(ex_rd),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .illegal(illegal)
    );

    id_ex_ctrl_pipe #(.ENABLE_MEXT(1), .ALUOP_W(5), .REG_AW(5)) dut_m (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .flush(flush),
        .stall(m_stall), .ex_valid(m_ex_valid), .ex_RegWrite(m_ex_RegWrite), .ex_MemWrite(m_ex_MemWrite),
        .ex_MemRead(m_ex_MemRead), .ex_ALUSrc(m_ex_ALUSrc), .ex_EXTOp(m_ex_EXTOp), .ex_ALUOp(m_ex_ALUOp),
        .ex_NPCOp(m_ex_NPCOp), .ex_WDSel(m_ex_WDSel), .ex_DMType(m_ex_DMType), .ex_rd(m_ex_rd),
        .ex_rs1(m_ex_rs1), .ex_rs2(m_ex_rs2), .illegal(m_illegal)
    );

    always #5 clk = ~clk;

    // Instruction encodings used below.
    localparam logic [31:0] ADD_3_1_2 = 32'h002081B3;
    localparam logic [31:0] LW_5_1    = 32'h0000A283;
    localparam logic [31:0] ADD_6_5_5 = 32'h00528333;
    localparam logic [31:0] LW_0_1    = 32'h0000A003;
    localparam logic [31:0] ADD_6_0_0 = 32'h00000333;
    localparam logic [31:0] MUL_0_1_2 = 32'h02208033;
    localparam logic [31:0] SRAI_1_3  = 32'h4030D093;
    localparam logic [31:0] BEQ_1_2   = 32'h00208463;
    localparam logic [31:0] JAL_1     = 32'h000000EF;

    // Flattened view of the control bundle of the non-M instance.
    function automatic logic [38:0] obs();
        return {ex_valid, ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc, ex_EXTOp, ex_ALUOp,
                ex_NPCOp, ex_WDSel, ex_DMType, ex_rd, ex_rs1, ex_rs2};
    endfunction

    function automatic logic [38:0] obs_m();
        return {m_ex_valid, m_ex_RegWrite, m_ex_MemWrite, m_ex_MemRead, m_ex_ALUSrc, m_ex_EXTOp, m_ex_ALUOp,
                m_ex_NPCOp, m_ex_WDSel, m_ex_DMType, m_ex_rd, m_ex_rs1, m_ex_rs2};
    endfunction

    function automatic logic [38:0] mk(input logic v, input logic rw, input logic mw, input logic mr,
                                       input logic src, input logic [5:0] ext, input logic [4:0] alu,
                                       input logic [2:0] npc, input logic [1:0] wd, input logic [2:0] dm,
                                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {v, rw, mw, mr, src, ext, alu, npc, wd, dm, rd, rs1, rs2};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; id_valid = 1'b0; id_inst = 32'h0; flush = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        total++;
        if (obs() !== 39'h0) begin bad++; $display("[TB] FAIL reset_bundle got %h want %h", obs(), 39'h0); end
        total++;
        if (illegal !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_flags got ill=%b stall=%b want 0 0", illegal, stall);
        end
    endtask

    task automatic test_basic_decode();
        logic [38:0] exp;
        id_valid = 1'b1; id_inst = ADD_3_1_2;
        step();
        exp = mk(1, 1, 0, 0, 0, 6'b0, 5'd3, 3'b000, 2'b00, 3'b000, 5'd3, 5'd1, 5'd2);
        total++;
        if (obs() !== exp) begin bad++; $display("[TB] FAIL add_decode got %h want %h", obs(), exp); end
        id_valid = 1'b0; id_inst = 32'h0;
        step();
        total++;
        if (obs() !== 39'h0) begin bad++; $display("[TB] FAIL idle_bubble got %h want %h", obs(), 39'h0); end
    endtask

    task automatic test_load_use();
        logic [38:0] exp;
        id_valid = 1'b1; id_inst = LW_5_1;
        step();
        exp = mk(1, 1, 0, 1, 1, 6'b010000, 5'd3, 3'b000, 2'b01, 3'b010, 5'd5, 5'd1, 5'd0);
        total++;
        if (obs() !== exp) begin bad++; $display("[TB] FAIL lw_decode got %h want %h", obs(), exp); end
        id_inst = ADD_6_5_5;
        #1;
        total++;
        if (stall !== 1'b1) begin bad++; $display("[TB] FAIL loaduse_stall got %b want 1", stall); end
        step();
        total++;
        if (obs() !== 39'h0 || stall !== 1'b0) begin
            bad++; $display("[TB] FAIL loaduse_bubble got %h stall=%b want %h stall=0", obs(), stall, 39'h0);
        end
        step();
        exp = mk(1, 1, 0, 0, 0, 6'b0, 5'd3, 3'b000, 2'b00, 3'b000, 5'd6, 5'd5, 5'd5);
        total++;
        if (obs() !== exp) begin bad++; $display("[TB] FAIL loaduse_issue got %h want %h", obs(), exp); end
    endtask

    task automatic test_rd_zero();
        logic [38:0] exp;
        id_inst = LW_0_1;
        step();
        id_inst = ADD_6_0_0;
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("[TB] FAIL rd0_no_stall got %b want 0", stall); end
        step();
        exp = mk(1, 1, 0, 0, 0, 6'b0, 5'd3, 3'b000, 2'b00, 3'b000, 5'd6, 5'd0, 5'd0);
        total++;
        if (obs() !== exp) begin bad++; $display("[TB] FAIL rd0_issue got %h want %h", obs(), exp); end
    endtask

    task automatic test_flush_over_stall();
        logic [38:0] exp;
        id_inst = LW_5_1;
        step();
        id_inst = ADD_6_5_5;
        #1;
        total++;
        if (stall !== 1'b1) begin bad++; $display("[TB] FAIL flush_pre_stall got %b want 1", stall); end
        flush = 1'b1;
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("[TB] FAIL flush_masks_stall got %b want 0", stall); end
        step();
        flush = 1'b0;
        total++;
        if (obs() !== 39'h0 || illegal !== 1'b0) begin
            bad++; $display("[TB] FAIL flush_bubble got %h ill=%b want %h ill=0", obs(), illegal, 39'h0);
        end
        step();
        exp = mk(1, 1, 0, 0, 0, 6'b0, 5'd3, 3'b000, 2'b00, 3'b000, 5'd6, 5'd5, 5'd5);
        total++;
        if (obs() !== exp) begin bad++; $display("[TB] FAIL post_flush_issue got %h want %h", obs(), exp); end
    endtask

    task automatic test_mext();
        logic [38:0] exp;
        id_inst = MUL_0_1_2;
        step();
        total++;
        if (obs() !== 39'h0 || illegal !== 1'b1) begin
            bad++; $display("[TB] FAIL mul_illegal got %h ill=%b want %h ill=1", obs(), illegal, 39'h0);
        end
        exp = mk(1, 1, 0, 0, 0, 6'b0, 5'd18, 3'b000, 2'b00, 3'b000, 5'd0, 5'd1, 5'd2);
        total++;
        if (obs_m() !== exp || m_illegal !== 1'b0) begin
            bad++; $display("[TB] FAIL mul_mext got %h ill=%b want %h ill=0", obs_m(), m_illegal, exp);
        end
        id_inst = ADD_3_1_2;
        step();
        total++;
        if (illegal !== 1'b0) begin bad++; $display("[TB] FAIL illegal_pulse got %b want 0", illegal); end
        id_valid = 1'b0; id_inst = MUL_0_1_2;
        step();
        total++;
        if (illegal !== 1'b0 || ex_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL illegal_gated got ill=%b v=%b want 0 0", illegal, ex_valid);
        end
        id_valid = 1'b1;
    endtask

    task automatic test_shift_branch_jump();
        logic [38:0] exp;
        id_inst = SRAI_1_3;
        step();
        exp = mk(1, 1, 0, 0, 1, 6'b100000, 5'd16, 3'b000, 2'b00, 3'b000, 5'd1, 5'd1, 5'd0);
        total++;
        if (obs() !== exp) begin bad++; $display("[TB] FAIL srai_decode got %h want %h", obs(), exp); end
        id_inst = BEQ_1_2;
        step();
        exp = mk(1, 0, 0, 0, 0, 6'b000100, 5'd4, 3'b001, 2'b00, 3'b000, 5'd0, 5'd1, 5'd2);
        total++;
        if (obs() !== exp) begin bad++; $display("[TB] FAIL beq_decode got %h want %h", obs(), exp); end
        id_inst = JAL_1;
        step();
        exp = mk(1, 1, 0, 0, 0, 6'b000001, 5'd0, 3'b010, 2'b10, 3'b000, 5'd1, 5'd0, 5'd0);
        total++;
        if (obs() !== exp) begin bad++; $display("[TB] FAIL jal_decode got %h want %h", obs(), exp); end
    endtask

    task automatic test_reset_mid_stream();
        id_inst = LW_5_1;
        step();
        id_inst = ADD_6_5_5;
        #1;
        total++;
        if (stall !== 1'b1) begin bad++; $display("[TB] FAIL midrst_pre_stall got %b want 1", stall); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        total++;
        if (obs() !== 39'h0 || stall !== 1'b0 || illegal !== 1'b0) begin
            bad++; $display("[TB] FAIL midrst_clear got %h stall=%b ill=%b want %h 0 0", obs(), stall, illegal, 39'h0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_decode();
        test_load_use();
        test_rd_zero();
        test_flush_over_stall();
        test_mext();
        test_shift_branch_jump();
        test_reset_mid_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
